// File: rtl/sfir_pkg.sv
// Shared types and width helpers for the symmetric FIR MAC sequencer.
// Also carries the default coefficient set that benches load into their ROM model.
package sfir_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } sfir_state_t;

    // Coefficient index width
    function automatic int sfir_aw(input int nbtap);
        return $clog2(nbtap);
    endfunction

    // Accumulator width: pre-add grows one bit, the nbtap-term sum grows aw bits
    function automatic int sfir_ow(input int dsize, input int csize, input int nbtap);
        return dsize + csize + 1 + $clog2(nbtap);
    endfunction

    localparam int sfir_def_nbtap = 4;
    localparam logic [3:0][15:0] sfir_def_coef = {16'd4, 16'd3, 16'd2, 16'd1};

endpackage

// File: rtl/sfir_delay_line.sv
// Enable-gated sample shift register with synchronous clear and parallel tap outputs.
// taps[0] holds the newest sample.
module sfir_delay_line
    import sfir_pkg::*;
#(
    parameter int dsize = 16,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [dsize-1:0]      din,
    output logic [depth-1:0][dsize-1:0]  taps
);

    logic [depth-1:0][dsize-1:0] taps_r;

    // Shift register: clear wins, otherwise shift only on an accepted sample
    always_ff @(posedge clk) begin
        if (clr) begin
            taps_r <= '0;
        end else if (en) begin
            taps_r <= {taps_r[depth-2:0], din};
        end else begin
            taps_r <= taps_r;
        end
    end

    assign taps = taps_r;

endmodule

// File: rtl/sfir_mac_sequencer.sv
// Time-multiplexed symmetric FIR: one pre-add/multiply/accumulate unit walks the nbtap
// tap pairs per accepted sample, then holds the result on a valid/ready output.
module sfir_mac_sequencer
    import sfir_pkg::*;
#(
    parameter  int dsize = 16,
    parameter  int csize = 16,
    parameter  int nbtap = 4,
    localparam int aw    = sfir_aw(nbtap),
    localparam int ow    = sfir_ow(dsize, csize, nbtap)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [dsize-1:0] in_data,
    output logic [aw-1:0]           coef_addr,
    input  logic signed [csize-1:0] coef_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ow-1:0]    out_data
);

    localparam logic [aw-1:0] k_last = aw'(nbtap - 1);
    localparam logic [aw:0]   hi_top = (aw + 1)'(2 * nbtap - 1);

    sfir_state_t                   state_r;
    sfir_state_t                   state_nx_s;
    logic [aw-1:0]                 k_r;
    logic signed [ow-1:0]          acc_r;
    logic signed [ow-1:0]          out_data_r;
    logic                          out_valid_r;
    logic                          in_ready_s;
    logic                          accept_s;
    logic [2*nbtap-1:0][dsize-1:0] taps_s;
    logic [aw:0]                   k_hi_s;
    logic signed [dsize-1:0]       tap_lo_s;
    logic signed [dsize-1:0]       tap_hi_s;
    logic signed [dsize:0]         pre_s;
    logic signed [dsize+csize:0]   prod_s;
    logic signed [ow-1:0]          sum_s;

    assign accept_s = in_valid & in_ready_s & ~rst;

    sfir_delay_line #(
        .dsize (dsize),
        .depth (2 * nbtap)
    ) u_delay_line (
        .clk  (clk),
        .clr  (rst),
        .en   (accept_s),
        .din  (in_data),
        .taps (taps_s)
    );

    // Pre-add of the symmetric pair selected by k, multiply, accumulate (restart at k=0)
    always_comb begin
        k_hi_s   = hi_top - {1'b0, k_r};
        tap_lo_s = taps_s[{1'b0, k_r}];
        tap_hi_s = taps_s[k_hi_s];
        pre_s    = (dsize + 1)'(tap_lo_s) + (dsize + 1)'(tap_hi_s);
        prod_s   = (dsize + csize + 1)'(pre_s) * (dsize + csize + 1)'(coef_data);
        if (k_r == {aw{1'b0}}) begin
            sum_s = ow'(prod_s);
        end else begin
            sum_s = acc_r + ow'(prod_s);
        end
    end

    // Next-state and input handshake; in DONE the input opens only when the result leaves
    always_comb begin
        state_nx_s = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_nx_s = S_MAC;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_MAC: begin
                if (k_r == k_last) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_MAC;
                end
            end
            S_DONE: begin
                in_ready_s = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_nx_s = S_MAC;
                    end else begin
                        state_nx_s = S_IDLE;
                    end
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Tap index, accumulator and output register; k returns to 0 after the last pair
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r         <= {aw{1'b0}};
            acc_r       <= {ow{1'b0}};
            out_data_r  <= {ow{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_MAC: begin
                    acc_r <= sum_s;
                    if (k_r == k_last) begin
                        out_data_r  <= sum_s;
                        out_valid_r <= 1'b1;
                        k_r         <= {aw{1'b0}};
                    end else begin
                        k_r <= k_r + aw'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    k_r <= {aw{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s & ~rst;
    assign coef_addr = k_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_sfir_mac_sequencer.sv
// Directed bench for sfir_mac_sequencer (nbtap=4, 16-bit samples/coefficients) with a
// golden symmetric-FIR model, latency tracking and hand-computed expected results.
module tb_sfir_mac_sequencer;
    import sfir_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  in_data;
    logic [1:0]          coef_addr;
    logic signed [15:0]  coef_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [34:0]  out_data;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    longint exp_q[$];
    longint got_q[$];
    longint lat_q[$];
    longint dl[8];
    logic signed [15:0] crom[4];
    bit     prev_ov;

    sfir_mac_sequencer #(.dsize(16), .csize(16), .nbtap(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign coef_data = crom[coef_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Golden model and scoreboard, sampled mid-cycle
    initial begin
        longint e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                lat_q.delete();
                for (int i = 0; i < 8; i++) dl[i] = 0;
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (lat_q.size() == 0) check("spurious_out_valid", 1, 0);
                    else check("latency", cyc - lat_q.pop_front(), 5);
                end
                if (out_valid && out_ready) begin
                    got_q.push_back(out_data);
                    if (exp_q.size() == 0) check("spurious_out_data", 1, 0);
                    else check("model_out_data", out_data, exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    for (int i = 7; i > 0; i--) dl[i] = dl[i-1];
                    dl[0] = in_data;
                    e = 0;
                    for (int k = 0; k < 4; k++) e += longint'(crom[k]) * (dl[k] + dl[7-k]);
                    exp_q.push_back(e);
                    lat_q.push_back(cyc);
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic send(input logic signed [15:0] d, input int gap, input bit hold,
                        output longint t_acc);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #2; end
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #2; n++; end
        if (n >= 100) check("send_timeout", n, 0);
        t_acc = cyc;
        @(posedge clk); #2;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin @(posedge clk); #2; n++; end
        if (n >= 300) check("drain_timeout", n, 0);
        repeat (2) begin @(posedge clk); #2; end
    endtask

    function automatic longint last_got();
        return (got_q.size() > 0) ? got_q[got_q.size()-1] : -1;
    endfunction

    initial begin
        longint t, tprev, held;
        int     n;
        int     imp_exp[8] = '{1, 2, 3, 4, 4, 3, 2, 1};

        for (int i = 0; i < 4; i++) crom[i] = sfir_def_coef[i];
        rst = 1'b1; in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_coef_addr", coef_addr, 0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #2;

        // 1: impulse response
        got_q.delete();
        send(16'sd1, 0, 1'b0, t);
        for (int i = 0; i < 7; i++) send(16'sd0, 1, 1'b0, t);
        drain();
        check("impulse_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check("impulse_out", (i < got_q.size()) ? got_q[i] : -1, imp_exp[i]);

        // 2: step with in_valid held high, one accept per 5 cycles
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(16'sd1, 0, (i < 7), t);
            if (i > 0) check("stream_period", t - tprev, 5);
            tprev = t;
        end
        drain();
        check("step_count", got_q.size(), 8);
        check("step_out8", last_got(), 20);

        // 3: extreme operands, result +2^33 without wrap
        for (int i = 0; i < 4; i++) crom[i] = -16'sd32768;
        got_q.delete();
        for (int i = 0; i < 8; i++) send(-16'sd32768, 0, 1'b0, t);
        drain();
        check("extreme_out8", last_got(), 64'sd8589934592);

        // 4: backpressure for 6 cycles, then result and next sample swap in one cycle
        for (int i = 0; i < 4; i++) crom[i] = sfir_def_coef[i];
        got_q.delete();
        out_ready = 1'b0;
        send(16'sd7, 0, 1'b1, t);
        in_data = 16'sd3;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #2; n++; end
        if (n >= 20) check("bp_wait_timeout", n, 0);
        held = out_data;
        check("bp_value", held, -622585);
        for (int i = 0; i < 6; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, held);
            check("bp_in_ready", in_ready, 0);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        #1 check("release_in_ready", in_ready, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        check("release_out_valid", out_valid, 0);
        drain();
        check("bp_count", got_q.size(), 2);

        // 5: reset at k=2 discards the result and clears the taps
        got_q.delete();
        send(16'sd5, 0, 1'b0, t);
        repeat (2) begin @(posedge clk); #2; end
        check("mac_coef_addr", coef_addr, 2);
        rst = 1'b1;
        #1 check("midrst_in_ready", in_ready, 0);
        @(posedge clk); #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_coef_addr", coef_addr, 0);
        rst = 1'b0;
        #1 check("midrst_post_in_ready", in_ready, 1);
        repeat (10) begin @(posedge clk); #2; end
        check("midrst_no_output", got_q.size(), 0);
        send(16'sd1, 0, 1'b0, t);
        drain();
        check("midrst_impulse", last_got(), 1);

        // 6: random idle gaps against the golden model
        got_q.delete();
        for (int i = 0; i < 12; i++) send(16'($urandom), int'($urandom_range(0, 7)), 1'b0, t);
        drain();
        check("gaps_count", got_q.size(), 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
